// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, frame width, default divider, parity helper.
// Both the transmitter and the receiver import this package so they agree on the frame.
package uart_tx_pkg;

  localparam int DATA_BITS        = 8;
  localparam int BAUD_DIV_DEFAULT = 156;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Divide-by-BAUD_DIV bit-time counter with synchronous clear; tick marks the last clock of a bit.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic resetb,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Bit-time counter: 0..BAUD_DIV-1, wraps, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr || (cnt_r == LAST)) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_tx.sv
// Double-buffered 8N1 UART transmitter (holding + shift register), LSB first, idle-high.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) before the stop bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
`ifdef UART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [7:0] wdata,
  input  logic       wr,
  output logic       thre,
  output logic       idle,
  output logic       txd
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e state_r;
  logic [7:0]  hold_r;
  logic [7:0]  shift_r;
  logic [2:0]  bit_cnt_r;
  logic        baud_tick_s;
  logic        baud_clr_s;
`ifdef UART_TX_PARITY_EN
  logic        par_r;
`endif

  // Bit timing restarts from zero on every hold->shift transfer out of IDLE.
  assign baud_clr_s = (state_r == ST_IDLE);

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk    (clk),
    .resetb (resetb),
    .clr    (baud_clr_s),
    .tick   (baud_tick_s)
  );

  // Transmit FSM, holding register, shifter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_r   <= ST_IDLE;
      hold_r    <= 8'h00;
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      thre      <= 1'b1;
      idle      <= 1'b1;
      txd       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      idle <= 1'b0;
      if (wr && thre) begin
        hold_r <= wdata;
        thre   <= 1'b0;
      end
      // A transfer needs thre=0 and a write needs thre=1, so the two never collide.
      case (state_r)
        ST_IDLE: begin
          if (!thre) begin
            shift_r <= hold_r;
            thre    <= 1'b1;
            state_r <= ST_START;
            txd     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_r   <= parity_bit(hold_r, 1'(PARITY_ODD));
`endif
          end else begin
            idle <= !wr;
          end
        end
        ST_START: begin
          if (baud_tick_s) begin
            state_r   <= ST_DATA;
            txd       <= shift_r[0];
            bit_cnt_r <= 3'd0;
          end
        end
        ST_DATA: begin
          if (baud_tick_s) begin
            if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_r <= ST_PARITY;
              txd     <= par_r;
`else
              state_r <= ST_STOP;
              txd     <= 1'b1;
`endif
            end else begin
              shift_r   <= {1'b0, shift_r[7:1]};
              txd       <= shift_r[1];
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick_s) begin
            state_r <= ST_STOP;
            txd     <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick_s) begin
            if (!thre) begin
              shift_r <= hold_r;
              thre    <= 1'b1;
              state_r <= ST_START;
              txd     <= 1'b0;
`ifdef UART_TX_PARITY_EN
              par_r   <= parity_bit(hold_r, 1'(PARITY_ODD));
`endif
            end else begin
              state_r <= ST_IDLE;
              idle    <= !wr;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          txd     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: reset, single frame, back-to-back, overrun,
// mid-frame reset and loopback bytes; parity frames when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

  localparam int BAUD_DIV = 156;
`ifdef UART_TX_PARITY_EN
  localparam int   NB   = 11;
  localparam logic PODD = 1'b0;
`else
  localparam int   NB   = 10;
`endif

  logic       clk;
  logic       resetb;
  logic [7:0] wdata;
  logic       wr;
  logic       thre;
  logic       idle;
  logic       txd;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx #(
    .BAUD_DIV   (BAUD_DIV)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD (int'(PODD))
`endif
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .wdata  (wdata),
    .wr     (wr),
    .thre   (thre),
    .idle   (idle),
    .txd    (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] d);
    wdata = d;
    wr    = 1'b1;
    step(1);
    wr    = 1'b0;
  endtask

  // Expected line level for bit slot k of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return (^d) ^ PODD;
`endif
    return 1'b1;
  endfunction

  // Called offset cycles after the start-bit edge; checks first and last clock of every bit,
  // rebuilds the byte like a receiver would, and leaves the caller just after the frame end edge.
  task automatic check_frame(input logic [7:0] d, input int offset, input logic thre_end);
    logic [7:0] rx;
    logic       e;
    rx = 8'h00;
    for (int k = 0; k < NB; k++) begin
      e = exp_bit(d, k);
      chk($sformatf("f%02h_b%0d_first", d, k), {7'd0, txd}, {7'd0, e});
      if (k == 0) step(BAUD_DIV - 1 - offset);
      else        step(BAUD_DIV - 1);
      chk($sformatf("f%02h_b%0d_last", d, k), {7'd0, txd}, {7'd0, e});
      if ((k >= 1) && (k <= 8)) rx[k-1] = txd;
      if (k == NB - 1) chk($sformatf("f%02h_thre_end", d), {7'd0, thre}, {7'd0, thre_end});
      step(1);
    end
    chk($sformatf("f%02h_rx_byte", d), rx, d);
  endtask

  logic bad;

  initial begin
    resetb = 1'b0;
    wr     = 1'b0;
    wdata  = 8'h00;
    step(2);
    chk("rst_txd",  {7'd0, txd},  8'd1);
    chk("rst_thre", {7'd0, thre}, 8'd1);
    chk("rst_idle", {7'd0, idle}, 8'd1);
    resetb = 1'b1;
    step(1);
    chk("post_rst_idle", {7'd0, idle}, 8'd1);

    // Basic frame 0x41 with 2-cycle wr->txd latency.
    write(8'h41);
    chk("wr_thre", {7'd0, thre}, 8'd0);
    chk("wr_idle", {7'd0, idle}, 8'd0);
    chk("wr_txd",  {7'd0, txd},  8'd1);
    step(1);
    chk("start_txd",  {7'd0, txd},  8'd0);
    chk("start_thre", {7'd0, thre}, 8'd1);
    check_frame(8'h41, 0, 1'b1);
    chk("basic_end_idle", {7'd0, idle}, 8'd1);
    chk("basic_end_txd",  {7'd0, txd},  8'd1);

    // Back-to-back 0x41,0x55 plus an overrun write of 0xFF that must be dropped.
    write(8'h41);
    step(1);
    chk("b2b_start_thre", {7'd0, thre}, 8'd1);
    write(8'h55);
    chk("b2b_q_thre", {7'd0, thre}, 8'd0);
    write(8'hFF);
    chk("ovr_thre", {7'd0, thre}, 8'd0);
    check_frame(8'h41, 2, 1'b0);
    chk("b2b_reload_thre", {7'd0, thre}, 8'd1);
    chk("b2b_reload_idle", {7'd0, idle}, 8'd0);
    check_frame(8'h55, 0, 1'b1);
    chk("b2b_end_idle", {7'd0, idle}, 8'd1);
    step(2 * BAUD_DIV);
    chk("ovr_no_frame_txd",  {7'd0, txd},  8'd1);
    chk("ovr_no_frame_idle", {7'd0, idle}, 8'd1);

    // Reset during data bit 3 with a byte queued behind it.
    write(8'h3C);
    step(1);
    step(4 * BAUD_DIV + 10);
    write(8'h99);
    chk("mid_q_thre", {7'd0, thre}, 8'd0);
    chk("mid_txd",    {7'd0, txd},  8'd1);
    resetb = 1'b0;
    step(1);
    chk("mid_rst_txd",  {7'd0, txd},  8'd1);
    chk("mid_rst_thre", {7'd0, thre}, 8'd1);
    chk("mid_rst_idle", {7'd0, idle}, 8'd1);
    resetb = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12 * BAUD_DIV; i++) begin
      step(1);
      if ((txd !== 1'b1) || (idle !== 1'b1) || (thre !== 1'b1)) bad = 1'b1;
    end
    chk("mid_rst_quiet", {7'd0, bad}, 8'd0);

    // Loopback-style bytes rebuilt from the line.
    write(8'h00);
    step(1);
    check_frame(8'h00, 0, 1'b1);
    write(8'hFF);
    step(1);
    check_frame(8'hFF, 0, 1'b1);
    write(8'hA5);
    step(1);
    check_frame(8'hA5, 0, 1'b1);
    chk("final_idle", {7'd0, idle}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
